vco_band_cal: RTL and testbench

VCO_BAND_CAL -- requirements
Module: vco_band_cal

---
 rtl/vco_band_cal.sv | 153 +++++++++++++++
 tb/tb_vco_band_cal.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vco_band_cal.sv
// vco_band_cal: coarse VCO band calibration by successive approximation.
// Each of the five tune bits is trialled MSB first. A trial waits SETTLE
// cycles for the VCO to settle, counts VCO rising edges for WINDOW cycles,
// and then keeps or clears the trial bit depending on whether the count
// exceeds TARGET.
//
// Handshake: start is a single-cycle request with no ready signal. It is
// taken on the edge where the FSM is in IDLE or FINISH and is dropped
// otherwise. busy=1 marks the cycles in which requests are ignored, and
// done=1 stays high until the next accepted request or reset.
module vco_band_cal #(
   parameter int WINDOW       = 1000,
   parameter int SETTLE       = 64,
   parameter int TARGET       = 70,
   parameter int CNT_W        = 16,
   parameter int TUNE_DEFAULT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             vco_clk,
   output logic [4:0]       tune,
   output logic             vcoin_hold,
   output logic             busy,
   output logic             done,
   output logic             cal_err,
   output logic [CNT_W-1:0] last_count,
   output logic [2:0]       dbgState
);

   localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_COUNT  = 3'd2,
      ST_DECIDE = 3'd3,
      ST_FINISH = 3'd4
   } stateT;

   stateT            state;
   stateT            nextState;
   logic             vcoSync1;
   logic             vcoSync2;
   logic             vcoSync3;
   logic             vcoRise;
   logic [TMR_W-1:0] timer;
   logic [CNT_W-1:0] edgeCnt;
   logic [2:0]       bitIdx;
   logic [4:0]       trialBit;
   logic [4:0]       decideTune;
   logic             settleDone;
   logic             windowDone;
   logic             aboveTarget;
   logic             startAccept;

   assign vcoRise     = vcoSync2 & ~vcoSync3;
   assign settleDone  = (timer == TMR_W'(SETTLE - 1));
   assign windowDone  = (timer == TMR_W'(WINDOW - 1));
   assign startAccept = start && ((state == ST_IDLE) || (state == ST_FINISH));
   assign trialBit    = 5'b00001 << bitIdx;

   // A saturated count means the true edge count is at least all-ones and
   // possibly far above it, so it is always treated as too fast.
   assign aboveTarget = (edgeCnt == '1) || (32'(edgeCnt) > TARGET);

   // Two-flop synchronizer plus a history flop for rising-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vcoSync1 <= 1'b0;
         vcoSync2 <= 1'b0;
         vcoSync3 <= 1'b0;
      end else begin
         vcoSync1 <= vco_clk;
         vcoSync2 <= vcoSync1;
         vcoSync3 <= vcoSync2;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= nextState;
   end

   // Next-state logic.
   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE, ST_FINISH: if (start) nextState = ST_SETTLE;
         ST_SETTLE:          if (settleDone) nextState = ST_COUNT;
         ST_COUNT:           if (windowDone) nextState = ST_DECIDE;
         ST_DECIDE:          nextState = (bitIdx == 3'd0) ? ST_FINISH : ST_SETTLE;
         default:            nextState = ST_IDLE;
      endcase
   end

   // Resolve the current trial bit and arm the next lower one.
   always_comb begin
      decideTune = aboveTarget ? (tune & ~trialBit) : tune;
      decideTune = decideTune | (trialBit >> 1);
   end

   // Datapath: settle/window timer, edge counter, trial code and result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tune       <= 5'(TUNE_DEFAULT);
         bitIdx     <= 3'd0;
         timer      <= '0;
         edgeCnt    <= '0;
         last_count <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_FINISH: begin
               timer <= '0;
               if (startAccept) begin
                  tune   <= 5'b10000;
                  bitIdx <= 3'd4;
               end
            end
            ST_SETTLE: begin
               if (settleDone) begin
                  timer   <= '0;
                  edgeCnt <= '0;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            ST_COUNT: begin
               timer <= windowDone ? '0 : timer + TMR_W'(1);
               if (vcoRise && (edgeCnt != '1)) edgeCnt <= edgeCnt + CNT_W'(1);
            end
            ST_DECIDE: begin
               last_count <= edgeCnt;
               tune       <= decideTune;
               if (bitIdx != 3'd0) bitIdx <= bitIdx - 3'd1;
            end
            default: timer <= '0;
         endcase
      end
   end

   // Outputs decoded from the state; done stays up for the whole FINISH stay.
   always_comb begin
      busy       = (state == ST_SETTLE) || (state == ST_COUNT) || (state == ST_DECIDE);
      vcoin_hold = busy;
      done       = (state == ST_FINISH);
      cal_err    = done && ((tune == 5'd0) || (tune == 5'd31));
      dbgState   = state;
   end

endmodule

// File: tb/tb_vco_band_cal.sv
// Bench for vco_band_cal: a per-cycle VCO phase model driven by the current
// tune code, a table of directed searches, randomized VCO curves checked
// against a successive-approximation reference, and hand-written sequences
// for reset mid-search, start while busy and restart from FINISH. A second
// instance with a 6-bit counter sees a fixed 9 MHz VCO throughout.
`timescale 1ns/1ps
module tb_vco_band_cal;

   localparam int WINDOW  = 1000;
   localparam int SETTLE  = 64;
   localparam int TARGET  = 70;
   localparam int PER_BIT = SETTLE + WINDOW + 1;
   localparam int TOTAL   = 5 * PER_BIT;

   typedef struct {
      string      name;
      int         base;     // VCO frequency at code 0, in 0.1 MHz units
      int         slope;    // frequency step per code, in 0.1 MHz units
      logic [4:0] expTune;
      int         expLast;
      logic       expErr;
   } vecT;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   logic start;
   logic vcoClk;
   logic satVcoClk;
   always #5 clk = ~clk;

   logic [4:0]  tune, satTune;
   logic        vcoinHold, satVcoinHold;
   logic        busy, satBusy;
   logic        done, satDone;
   logic        calErr, satCalErr;
   logic [15:0] lastCount;
   logic [5:0]  satLastCount;
   logic [2:0]  dbgState, satDbgState;

   vco_band_cal dut (
      .clk(clk), .rst(rst), .start(start), .vco_clk(vcoClk),
      .tune(tune), .vcoin_hold(vcoinHold), .busy(busy), .done(done),
      .cal_err(calErr), .last_count(lastCount), .dbgState(dbgState)
   );

   vco_band_cal #(.CNT_W(6)) satDut (
      .clk(clk), .rst(rst), .start(start), .vco_clk(satVcoClk),
      .tune(satTune), .vcoin_hold(satVcoinHold), .busy(satBusy), .done(satDone),
      .cal_err(satCalErr), .last_count(satLastCount), .dbgState(satDbgState)
   );

   // ---------------- VCO models ----------------
   // Phase is kept in thousandths of a VCO cycle. One 10 ns clk period at
   // f = n*0.1 MHz advances the phase by n/1000 of a cycle.
   int base  = 55;
   int slope = 1;
   int phase;
   int satPhase;

   initial begin
      phase     = $urandom_range(0, 999);
      satPhase  = $urandom_range(0, 999);
      vcoClk    = 1'b0;
      satVcoClk = 1'b0;
   end

   always @(negedge clk) begin
      phase     = (phase + base + slope * int'(tune)) % 1000;
      vcoClk    = (phase < 500);
      satPhase  = (satPhase + 90) % 1000;
      satVcoClk = (satPhase < 500);
   end

   // ---------------- scoreboard ----------------
   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Edges in one window = f * WINDOW / 100 MHz; with f in 0.1 MHz units
   // this is f * WINDOW / 1000.
   function automatic int modelCount(input int b, input int s, input int code);
      return ((b + s * code) * WINDOW) / 1000;
   endfunction

   // Binary search on the monotonic count(code) curve, MSB first.
   task automatic modelSearch(input int b, input int s,
                              output logic [4:0] code, output int lastCnt);
      int c;
      int trial;
      c = 0;
      lastCnt = 0;
      for (int bitPos = 4; bitPos >= 0; bitPos--) begin
         trial   = c | (1 << bitPos);
         lastCnt = modelCount(b, s, trial);
         if (lastCnt <= TARGET) c = trial;
      end
      code = 5'(c);
   endtask

   // ---------------- driver ----------------
   // Called at a negedge: start is raised there and accepted on the next
   // posedge. Returns the number of edges from the accept edge to the one on
   // which done is first seen. restartAt re-pulses start at that cycle and
   // abortAt returns early (caller then handles the abort).
   task automatic runCal(input string tag, input int restartAt, input int abortAt,
                         output int cycles);
      int n;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, ".acceptTune"}, int'(tune), 16);
      check({tag, ".acceptBusy"}, int'(busy), 1);
      check({tag, ".acceptDone"}, int'(done), 0);
      check({tag, ".acceptErr"}, int'(calErr), 0);
      n = 0;
      cycles = -1;
      while (n < TOTAL + 200) begin
         @(posedge clk);
         n++;
         #1;
         start = (n == restartAt);
         if (n == SETTLE + 36) begin
            check({tag, ".holdInCount"}, int'(vcoinHold), 1);
            check({tag, ".tuneInCount"}, int'(tune), 16);
         end
         if (n == abortAt) return;
         if (done) begin
            cycles = n;
            break;
         end
      end
      start = 1'b0;
      check({tag, ".doneSeen"}, int'(done), 1);
   endtask

   task automatic checkResult(input string tag, input logic [4:0] expTune,
                              input int expLast, input logic expErr, input int cycles);
      check({tag, ".cycles"}, cycles, TOTAL);
      check({tag, ".tune"}, int'(tune), int'(expTune));
      check({tag, ".lastCount"}, int'(lastCount), expLast);
      check({tag, ".calErr"}, int'(calErr), int'(expErr));
      check({tag, ".busy"}, int'(busy), 0);
      check({tag, ".hold"}, int'(vcoinHold), 0);
      check({tag, ".satTune"}, int'(satTune), 0);
      check({tag, ".satLast"}, int'(satLastCount), 63);
      check({tag, ".satErr"}, int'(satCalErr), 1);
      repeat (5) @(posedge clk);
      #1;
      check({tag, ".tuneHeld"}, int'(tune), int'(expTune));
      check({tag, ".doneHeld"}, int'(done), 1);
   endtask

   // ---------------- test sequence ----------------
   vecT vecTable[3];

   initial begin
      int         cycles;
      logic [4:0] mTune;
      int         mLast;

      vecTable[0] = '{name: "nominal",  base: 55, slope: 1, expTune: 5'd15, expLast: 70, expErr: 1'b0};
      vecTable[1] = '{name: "lowRail",  base: 90, slope: 0, expTune: 5'd0,  expLast: 90, expErr: 1'b1};
      vecTable[2] = '{name: "highRail", base: 30, slope: 0, expTune: 5'd31, expLast: 30, expErr: 1'b1};

      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.tune", int'(tune), 15);
      check("reset.busy", int'(busy), 0);
      check("reset.hold", int'(vcoinHold), 0);
      check("reset.done", int'(done), 0);
      check("reset.calErr", int'(calErr), 0);
      check("reset.lastCount", int'(lastCount), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle.tune", int'(tune), 15);

      // Directed table; each run after the first also starts from FINISH.
      for (int i = 0; i < 3; i++) begin
         base  = vecTable[i].base;
         slope = vecTable[i].slope;
         @(negedge clk);
         runCal(vecTable[i].name, -1, -1, cycles);
         checkResult(vecTable[i].name, vecTable[i].expTune, vecTable[i].expLast,
                     vecTable[i].expErr, cycles);
      end

      // Randomized VCO curves against the reference search.
      for (int i = 0; i < 4; i++) begin
         base  = $urandom_range(40, 85);
         slope = $urandom_range(1, 2);
         modelSearch(base, slope, mTune, mLast);
         @(negedge clk);
         runCal($sformatf("rand%0d", i), -1, -1, cycles);
         checkResult($sformatf("rand%0d", i), mTune, mLast,
                     (mTune == 5'd0) || (mTune == 5'd31), cycles);
      end

      // Start re-pulsed during SETTLE of bit 3 must be ignored.
      base  = 55;
      slope = 1;
      @(negedge clk);
      runCal("busyStart", PER_BIT + 10, -1, cycles);
      checkResult("busyStart", 5'd15, 70, 1'b0, cycles);

      // Reset asserted mid-cycle during COUNT of bit 2.
      @(negedge clk);
      runCal("midReset", -1, 2 * PER_BIT + SETTLE + 400, cycles);
      check("midReset.busyBefore", int'(busy), 1);
      #2;
      rst = 1'b1;
      #1;
      check("midReset.tune", int'(tune), 15);
      check("midReset.busy", int'(busy), 0);
      check("midReset.hold", int'(vcoinHold), 0);
      check("midReset.done", int'(done), 0);
      check("midReset.lastCount", int'(lastCount), 0);
      @(negedge clk);
      rst = 1'b0;
      runCal("rerun", -1, -1, cycles);
      checkResult("rerun", 5'd15, 70, 1'b0, cycles);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
